// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared state type and sizing helper for the binary GCD unit
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STRIP,
    LOOP,
    DONE
  } gcd_state_t;

  // Width of the common power-of-two counter for a given operand width.
  function automatic int k_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/gcd_bin_if.sv
// rtl/gcd_bin_if.sv - operand/result handshake bundle for gcd_bin (cycles member only with GCD_BIN_CYCLES_EN)
interface gcd_bin_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);

  typedef logic [CNT_W-1:0] cnt_t;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] o;
  logic             out_valid;
  logic             out_ready;
`ifdef GCD_BIN_CYCLES_EN
  cnt_t             cycles;
`endif

  modport master (
    output a, b, in_valid, out_ready,
    input  in_ready, o, out_valid
`ifdef GCD_BIN_CYCLES_EN
    , input cycles
`endif
  );

  modport slave (
    input  a, b, in_valid, out_ready,
    output in_ready, o, out_valid
`ifdef GCD_BIN_CYCLES_EN
    , output cycles
`endif
  );

endinterface

// File: rtl/gcd_bin_step.sv
// rtl/gcd_bin_step.sv - one Stein iteration: next x/y/k/state for STRIP and LOOP
module gcd_bin_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int KW    = 5
) (
  input  gcd_state_t       state,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [KW-1:0]    k,
  output gcd_state_t       state_n,
  output logic [WIDTH-1:0] x_n,
  output logic [WIDTH-1:0] y_n,
  output logic [KW-1:0]    k_n
);

  // Single shift-or-subtract decision; y==0 is tested first so zero operands terminate.
  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    k_n     = k;
    if (state == STRIP) begin
      if (y == '0) begin
        state_n = DONE;
      end else if (!x[0] && !y[0]) begin
        x_n = x >> 1;
        y_n = y >> 1;
        k_n = k + 1'b1;
      end else begin
        state_n = LOOP;
      end
    end else if (state == LOOP) begin
      if (y == '0) begin
        state_n = DONE;
      end else if (!x[0]) begin
        x_n = x >> 1;
      end else if (!y[0]) begin
        y_n = y >> 1;
      end else if (x > y) begin
        x_n = y;
        y_n = x - y;
      end else begin
        y_n = y - x;
      end
    end
  end

endmodule

// File: rtl/gcd_bin.sv
// rtl/gcd_bin.sv - binary GCD with valid/ready on both sides; GCD_BIN_CYCLES_EN adds the cycles output
module gcd_bin
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  gcd_bin_if.slave   bus
);

  localparam int KW = k_width(WIDTH);

  typedef logic [CNT_W-1:0] cnt_t;

  gcd_state_t       state_q, state_d, step_state;
  logic [WIDTH-1:0] x_q, x_d, step_x;
  logic [WIDTH-1:0] y_q, y_d, step_y;
  logic [KW-1:0]    k_q, k_d, step_k;
  logic [WIDTH-1:0] o_q, o_d;
  logic             accept;

  gcd_bin_step #(.WIDTH(WIDTH), .KW(KW)) u_step (
    .state   (state_q),
    .x       (x_q),
    .y       (y_q),
    .k       (k_q),
    .state_n (step_state),
    .x_n     (step_x),
    .y_n     (step_y),
    .k_n     (step_k)
  );

  // Ready in IDLE, or in DONE when the result leaves this cycle so the next job starts without a bubble.
  assign bus.in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.o         = o_q;

  // Next-state: load on accept, iterate in STRIP/LOOP, latch the shifted result on entry to DONE.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    k_d     = k_q;
    o_d     = o_q;
    case (state_q)
      STRIP, LOOP: begin
        state_d = step_state;
        x_d     = step_x;
        y_d     = step_y;
        k_d     = step_k;
        if (step_state == DONE) o_d = x_q << k_q;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: ;
    endcase
    if (accept) begin
      state_d = STRIP;
      k_d     = '0;
      if (bus.a == '0) begin
        x_d = bus.b;
        y_d = '0;
      end else begin
        x_d = bus.a;
        y_d = bus.b;
      end
    end
  end

  // Datapath and state registers; reset abandons any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      o_q     <= o_d;
    end
  end

`ifdef GCD_BIN_CYCLES_EN
  cnt_t cnt_q, cnt_d;

  // Busy-cycle count: clears on accept, saturates, and holds while the result waits.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if ((state_q == STRIP) || (state_q == LOOP)) begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus.cycles = cnt_q;
`endif

endmodule

// File: tb/tb_gcd_bin.sv
// tb/tb_gcd_bin.sv - self-checking bench for gcd_bin against an Euclid reference model
module tb_gcd_bin;

  localparam int W       = 16;
  localparam int CW      = 16;
  localparam int LAT_MAX = 3 * W + 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gcd_bin_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  gcd_bin #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_done   = 0;
  int acc_cyc  = 0;
  int last_lat = 0;
  bit seen_valid = 1'b0;
  bit hold_prev  = 1'b0;
  bit rand_bp    = 1'b0;
  logic [W-1:0] prev_o;
  logic [W-1:0] last_o;
  logic [W-1:0] exp_q[$];
`ifdef GCD_BIN_CYCLES_EN
  logic [CW-1:0] last_cycles;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] p = a;
    logic [W-1:0] q = b;
    logic [W-1:0] t;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Compare process: every negedge, outputs against the reference queue.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_prev  = 1'b0;
      seen_valid = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_o", bus.o, prev_o);
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          chk("result", bus.o, exp_q[0]);
          if (!seen_valid) begin
            seen_valid = 1'b1;
            last_lat   = cyc - acc_cyc;
            chk("latency_le_bound", (last_lat <= LAT_MAX), 1);
          end
          if (bus.out_ready) begin
            last_o = bus.o;
`ifdef GCD_BIN_CYCLES_EN
            last_cycles = bus.cycles;
`endif
            n_done++;
            void'(exp_q.pop_front());
            seen_valid = 1'b0;
          end
        end
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      prev_o    = bus.o;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(gcd_ref(bus.a, bus.b));
        acc_cyc = cyc;
      end
    end
  end

  // Random backpressure during the random phase.
  always @(posedge clk) begin
    #1;
    if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  // Offers one operand pair and returns (at posedge+1) once it has been accepted.
  task automatic start_job(input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok = 1'b0;
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
  endtask

  task automatic wait_done(input int target);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (n_done >= target) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) chk("result_timeout", n_done, target);
  endtask

  task automatic job(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] exp);
    int t = n_done + 1;
    start_job(a, b);
    wait_done(t);
    chk(name, last_o, exp);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int n0;
    bit ok;

    bus.a = '0;
    bus.b = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("reset_in_ready", bus.in_ready, 0);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_o", bus.o, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("post_reset_in_ready", bus.in_ready, 1);

    @(posedge clk);
    #1;
    job("gcd_48_18", 16'd48, 16'd18, 16'd6);
    chk("single_pulse", bus.out_valid, 0);
    chk("lat_48_18", last_lat, 10);
`ifdef GCD_BIN_CYCLES_EN
    chk("cycles_48_18", last_cycles, 9);
`endif

    job("gcd_0_0", 16'd0, 16'd0, 16'd0);
    chk("lat_0_0_le2", (last_lat <= 2), 1);
    job("gcd_0_40", 16'd0, 16'd40, 16'd40);
    chk("lat_0_40_le2", (last_lat <= 2), 1);
    job("gcd_35_0", 16'd35, 16'd0, 16'd35);
    chk("lat_35_0_le2", (last_lat <= 2), 1);
    job("gcd_ffff_1", 16'hFFFF, 16'h0001, 16'h0001);
    chk("lat_ffff_1_le51", (last_lat <= 51), 1);
    job("gcd_8000_4000", 16'h8000, 16'h4000, 16'h4000);

    // Backpressure with a new job waiting, then same-cycle handoff.
    bus.out_ready = 1'b0;
    n0 = n_done;
    start_job(16'd100, 16'd75);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("bp_reaches_valid", ok, 1);
    bus.a = 16'd12;
    bus.b = 16'd8;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid_held", bus.out_valid, 1);
      chk("bp_o_held", bus.o, 25);
      chk("bp_in_ready_low", bus.in_ready, 0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    chk("handoff_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    chk("bp_result", last_o, 25);
    chk("no_bubble_busy_in_ready", bus.in_ready, 0);
    chk("no_bubble_out_valid", bus.out_valid, 0);
    wait_done(n0 + 2);
    chk("handoff_result", last_o, 4);

    // Reset in the middle of LOOP discards the job.
    n0 = n_done;
    start_job(16'd1000, 16'd750);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_idle_ready", bus.in_ready, 1);
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_result", n_done, n0);
    job("gcd_21_14", 16'd21, 16'd14, 16'd7);

    // Random pairs with random backpressure.
    rand_bp = 1'b1;
    for (int j = 0; j < 1500; j++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 9))
        0: ra = '0;
        1: rb = '0;
        2: rb = ra;
        3: begin ra = W'($urandom_range(0, 15)); rb = W'($urandom_range(0, 15)); end
        4: begin ra = '0; rb = '0; end
        default: ;
      endcase
      n0 = n_done;
      start_job(ra, rb);
      wait_done(n0 + 1);
    end
    rand_bp = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
